// File: rtl/ev22_pkg.sv
// EV22 fetch-queue defaults and fetch state encoding shared by the queue and its FIFO.
package ev22_pkg;

  localparam int unsigned EV22_IW       = 20;
  localparam int unsigned EV22_AW       = 16;
  localparam logic [15:0] EV22_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/ev22_fetchq_fifo.sv
// Synchronous FIFO for fetched {instruction, pc} entries; wrap-around pointers
// carry one extra bit to tell full from empty. Clear has priority over push/pop.
module ev22_fetchq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q, rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[PW-1:0]] <= wdata_i;
        wr_q                <= wr_q + ONE;
      end
      if (pop_i) begin
        rd_q <= rd_q + ONE;
      end
    end
  end

  assign rdata_o = mem_q[rd_q[PW-1:0]];
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW-1:0] == rd_q[PW-1:0]) && (wr_q[PW] != rd_q[PW]);

endmodule

// File: rtl/ev22_fetch_queue.sv
// EV22 instruction fetch queue: owns the PC, issues one outstanding program-memory read,
// buffers returned instructions for decode. Define FETCHQ_BYPASS_EN for same-cycle empty-queue bypass.
module ev22_fetch_queue
  import ev22_pkg::*;
#(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   IW       = EV22_IW,
  parameter int unsigned   AW       = EV22_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(EV22_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pmem_req,
  output logic [AW-1:0] pmem_addr,
  input  logic          pmem_ack,
  input  logic [IW-1:0] pmem_data,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready
);

  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  fetch_state_e     state_q;
  logic             req_q;
  logic [AW-1:0]    addr_q, pc_q, pc_inc_d;
  logic             ack_req, bypass;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [IW+AW-1:0] fifo_rdata;

  assign ack_req  = pmem_ack && (state_q == ST_REQ);
  assign pc_inc_d = pc_q + AW'(1);

`ifdef FETCHQ_BYPASS_EN
  assign bypass     = fifo_empty && ack_req && !flush;
  assign inst       = bypass ? pmem_data : fifo_rdata[IW+AW-1:AW];
  assign inst_pc    = bypass ? pc_q : fifo_rdata[AW-1:0];
  assign inst_valid = bypass || !fifo_empty;
`else
  assign bypass     = 1'b0;
  assign inst       = fifo_rdata[IW+AW-1:AW];
  assign inst_pc    = fifo_rdata[AW-1:0];
  assign inst_valid = !fifo_empty;
`endif

  assign fifo_push = ack_req && !flush && !(bypass && inst_ready);
  assign fifo_pop  = !fifo_empty && inst_ready && !flush;

  ev22_fetchq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IW + AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (flush),
    .wdata_i ({pmem_data, pc_q}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (flush || !fifo_full) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= flush ? flush_pc : pc_q;
          end
          if (flush) pc_q <= flush_pc;
        end
        ST_REQ: begin
          if (flush) begin
            pc_q <= flush_pc;
            if (pmem_ack) addr_q  <= flush_pc;
            else          state_q <= ST_DISCARD;
          end else if (pmem_ack) begin
            pc_q <= pc_inc_d;
            // Pre-pop count: the slot just filled must leave room, so full never overlaps a request
            if (fifo_count < LAST) begin
              addr_q <= pc_inc_d;
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (flush) pc_q <= flush_pc;
          if (pmem_ack) begin
            state_q <= ST_REQ;
            addr_q  <= flush ? flush_pc : pc_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_req  = req_q;
  assign pmem_addr = addr_q;

endmodule
